// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, decode valid/ready
// stream and the control unit's redirect inputs.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        pc_src;
  logic [31:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, pc_src, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, pc_src, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one imem read in
// flight and feeds decode through a 2-entry prefetch FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] target;
  logic [1:0]  count, count_n;
  logic [31:0] buf_pc   [2];
  logic [31:0] buf_data [2];
  logic        rd_ptr, wr_ptr;
  logic        push, pop;

  assign target          = bus.branch_target & ~32'h3;
  assign bus.imem_req    = (state != IDLE);
  assign bus.imem_addr   = req_addr;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = buf_data[rd_ptr];
  assign bus.instr_pc    = buf_pc[rd_ptr];

  // req_addr is separate from pc so DROP can hold the abandoned address
  // while pc already tracks the redirect target.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    push       = (state == WAIT) && bus.imem_ack && !bus.pc_src;
    pop        = bus.instr_valid && bus.instr_ready && !bus.pc_src;
    count_n    = count + 2'(push) - 2'(pop);
    if (bus.pc_src) begin
      count_n = '0;
      pc_n    = target;
      if ((state != IDLE) && !bus.imem_ack) begin
        state_n = DROP;
      end else begin
        state_n    = WAIT;
        req_addr_n = target;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (count_n < 2'd2) begin
            state_n    = WAIT;
            req_addr_n = pc;
          end
        end
        WAIT: begin
          if (bus.imem_ack) begin
            pc_n = pc + 32'd4;
            if (count_n < 2'd2) req_addr_n = pc_n;
            else                state_n    = IDLE;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state_n    = WAIT;
            req_addr_n = pc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      count       <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      count    <= count_n;
      if (bus.pc_src) begin
        wr_ptr <= rd_ptr;
      end else begin
        if (push) begin
          buf_pc[wr_ptr]   <= pc;
          buf_data[wr_ptr] <= bus.imem_rdata;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing cases plus randomized traffic checked
// against an in-order PC stream model with a latency-programmable memory.
module tb_fetch_unit;
  logic clk;
  logic reset;

  fetch_unit_if bus();
  fetch_unit_if bus2();

  fetch_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          lat;
  int          wait_cnt;
  logic [31:0] data_xor;
  logic        ready_v, redir_v;
  logic [31:0] target_v;
  logic [31:0] exp_pc, exp_pc2, last_pc;
  logic [31:0] s_req, s_ack, s_valid, s_addr, s_pc, s_instr;
  int          n_deliv, n_ack;
  logic        prev_pend, prev_hold;
  logic [31:0] prev_addr, prev_instr, prev_ipc;
  logic [31:0] q2[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(bus.imem_req), 32'd0);
    check_eq({tag, "_addr"},  bus.imem_addr, 32'h0000_0000);
    check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check_eq({tag, "_instr"}, bus.instr, 32'd0);
    check_eq({tag, "_ipc"},   bus.instr_pc, 32'd0);
    check_eq({tag, "_addr2"}, bus2.imem_addr, 32'hFFFF_FFF8);
  endtask

  task automatic clear_model();
    exp_pc    = 32'h0000_0000;
    exp_pc2   = 32'hFFFF_FFF8;
    wait_cnt  = 0;
    prev_pend = 1'b0;
    prev_hold = 1'b0;
    n_deliv   = 0;
    n_ack     = 0;
    last_pc   = 32'hFFFF_FFFF;
    q2.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  // One clock: drive inputs at negedge, sample and score, then advance memory.
  task automatic cycle();
    @(negedge clk);
    bus.imem_ack       = bus.imem_req && (wait_cnt >= lat - 1);
    bus.imem_rdata     = bus.imem_ack ? (bus.imem_addr ^ data_xor) : 32'hDEAD_BEEF;
    bus.instr_ready    = ready_v;
    bus.pc_src         = redir_v;
    bus.branch_target  = target_v;
    bus2.imem_ack      = bus2.imem_req;
    bus2.imem_rdata    = bus2.imem_addr;
    bus2.instr_ready   = 1'b1;
    bus2.pc_src        = 1'b0;
    bus2.branch_target = '0;
    #1;
    s_req   = 32'(bus.imem_req);
    s_ack   = 32'(bus.imem_ack);
    s_valid = 32'(bus.instr_valid);
    s_addr  = bus.imem_addr;
    s_pc    = bus.instr_pc;
    s_instr = bus.instr;
    if (s_req != 0) check_eq("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
    if (prev_pend) begin
      check_eq("req_held", s_req, 32'd1);
      check_eq("addr_held", s_addr, prev_addr);
    end
    if (prev_hold) begin
      check_eq("valid_held", s_valid, 32'd1);
      check_eq("instr_held", s_instr, prev_instr);
      check_eq("ipc_held", s_pc, prev_ipc);
    end
    if ((s_valid != 0) && ready_v && !redir_v) begin
      check_eq("deliv_pc", s_pc, exp_pc);
      check_eq("deliv_instr", s_instr, exp_pc ^ data_xor);
      exp_pc  = exp_pc + 32'd4;
      last_pc = s_pc;
      n_deliv++;
    end
    if (redir_v) exp_pc = target_v & ~32'h3;
    if ((s_req != 0) && (s_ack != 0)) n_ack++;
    prev_pend  = (s_req != 0) && (s_ack == 0);
    prev_addr  = s_addr;
    prev_hold  = (s_valid != 0) && !ready_v && !redir_v;
    prev_instr = s_instr;
    prev_ipc   = s_pc;
    if (bus2.instr_valid) begin
      check_eq("wrap_pc", bus2.instr_pc, exp_pc2);
      check_eq("wrap_instr", bus2.instr, exp_pc2);
      q2.push_back(bus2.instr_pc);
      exp_pc2 = exp_pc2 + 32'd4;
    end
    @(posedge clk);
    if ((s_req != 0) && (s_ack != 0)) wait_cnt = 0;
    else if (s_req != 0)              wait_cnt++;
    else                              wait_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   d0;
    logic found;
    reset = 1'b1;
    lat = 1; data_xor = '0; ready_v = 1'b1; redir_v = 1'b0; target_v = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.pc_src = 1'b0; bus.branch_target = '0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.instr_ready = 1'b0;
    bus2.pc_src = 1'b0; bus2.branch_target = '0;
    clear_model();

    // Streaming with single-cycle memory; dut_wrap shows PC wraparound.
    apply_reset();
    cycle();
    check_eq("t1_req", s_req, 32'd1);
    check_eq("t1_addr", s_addr, 32'd0);
    check_eq("t1_valid0", s_valid, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("t1_valid", s_valid, 32'd1);
      check_eq("t1_pc", s_pc, 32'(k * 4));
      check_eq("t1_instr", s_instr, 32'(k * 4));
    end
    check_eq("t5_count", 32'(q2.size() >= 3), 32'd1);
    if (q2.size() >= 3) begin
      check_eq("t5_pc0", q2[0], 32'hFFFF_FFF8);
      check_eq("t5_pc1", q2[1], 32'hFFFF_FFFC);
      check_eq("t5_pc2", q2[2], 32'h0000_0000);
    end

    // Decode stalled: buffer fills to two entries and fetch stops.
    ready_v = 1'b0;
    apply_reset();
    repeat (6) cycle();
    check_eq("t2_acks", 32'(n_ack), 32'd2);
    check_eq("t2_req", s_req, 32'd0);
    check_eq("t2_valid", s_valid, 32'd1);
    check_eq("t2_instr", s_instr, 32'd0);
    check_eq("t2_ipc", s_pc, 32'd0);
    ready_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("t2_deliv", 32'(n_deliv), 32'(k + 1));
      check_eq("t2_last", last_pc, 32'(k * 4));
    end

    // Redirect while a 3-cycle request is outstanding.
    lat = 3;
    apply_reset();
    cycle();
    check_eq("t3_wait1", s_ack, 32'd0);
    redir_v = 1'b1; target_v = 32'h0000_0103;
    cycle();
    redir_v = 1'b0;
    check_eq("t3_wait2", s_ack, 32'd0);
    cycle();
    check_eq("t3_drop_ack", s_ack, 32'd1);
    check_eq("t3_drop_addr", s_addr, 32'd0);
    cycle();
    check_eq("t3_new_req", s_req, 32'd1);
    check_eq("t3_new_addr", s_addr, 32'h0000_0100);
    for (int k = 0; k < 10 && n_deliv == 0; k++) cycle();
    check_eq("t3_ndeliv", 32'(n_deliv), 32'd1);
    check_eq("t3_pc", last_pc, 32'h0000_0100);

    // Redirect coinciding with an ack and a decode handshake.
    lat = 1;
    apply_reset();
    repeat (3) cycle();
    redir_v = 1'b1; target_v = 32'h0000_0100;
    cycle();
    redir_v = 1'b0;
    check_eq("t4_coinc_valid", s_valid, 32'd1);
    check_eq("t4_coinc_ack", s_ack, 32'd1);
    d0 = n_deliv;
    cycle();
    check_eq("t4_empty", s_valid, 32'd0);
    check_eq("t4_req", s_req, 32'd1);
    check_eq("t4_addr", s_addr, 32'h0000_0100);
    cycle();
    check_eq("t4_ndeliv", 32'(n_deliv), 32'(d0 + 1));
    check_eq("t4_pc", last_pc, 32'h0000_0100);

    // Asynchronous reset with a request outstanding, then a stale ack.
    lat = 3; ready_v = 1'b0;
    apply_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      found = (s_valid != 0) && (s_req != 0) && (s_ack == 0);
    end
    check_eq("t6_setup", 32'(found), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    reset = 1'b1;
    clear_model();
    cycle();
    check_eq("t6_req", s_req, 32'd1);
    check_eq("t6_addr", s_addr, 32'd0);
    check_eq("t6_valid", s_valid, 32'd0);
    ready_v = 1'b1;
    for (int k = 0; k < 12 && n_deliv == 0; k++) cycle();
    check_eq("t6_ndeliv", 32'(n_deliv), 32'd1);
    check_eq("t6_pc", last_pc, 32'd0);

    // Randomized traffic: latency, stalls, redirects and data pattern.
    for (int seg = 0; seg < 8; seg++) begin
      lat = $urandom_range(1, 4);
      data_xor = $urandom();
      ready_v = 1'b1;
      redir_v = 1'b0;
      apply_reset();
      for (int c = 0; c < 250; c++) begin
        ready_v  = ($urandom_range(0, 9) < 7);
        redir_v  = ($urandom_range(0, 19) == 0);
        target_v = $urandom();
        cycle();
      end
      redir_v = 1'b0;
      check_eq("rand_progress", 32'(n_deliv > 10), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
